vdp_super_res_fetch: RTL

VDP_SUPER_RES_FETCH -- requirements
Module: vdp_super_res_fetch

---
 rtl/vdp_super_res_fetch_if.sv | 14 +
 rtl/vdp_super_res_fetch.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vdp_super_res_fetch_if.sv
// VRAM read handshake between the super-res fetcher (master) and the VRAM arbiter (slave).
// The request is held with a stable address until the acknowledge cycle, and read data is valid in that same cycle.
interface vdp_super_res_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18
) ();
  logic              vram_req;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_ack;
  logic [DATA_W-1:0] vram_rdata;

  modport master (output vram_req, vram_addr, input vram_ack, vram_rdata);
  modport slave  (input vram_req, vram_addr, output vram_ack, vram_rdata);
endinterface

// File: rtl/vdp_super_res_fetch.sv
// Super-resolution line fetcher: it prefetches VRAM words into a small FIFO and serialises them LSB-first into palette indices.
// Each line base is set up at the line reload column.
module vdp_super_res_fetch #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 18,
  parameter int RELOAD_X   = 720
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vdp_super,
  input  logic [9:0]        cx,
  input  logic              last_line,
  input  logic              on_a_visible_line,
  input  logic [1:0]        bpp_mode,
  input  logic [9:0]        view_start_x,
  input  logic [9:0]        view_end_x,
  input  logic [ADDR_W-1:0] page_addr,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic [9:0]        words_per_line,
  input  logic [5:0]        palette_bank,
  input  logic [7:0]        frame_col,
  vdp_super_res_fetch_if.master vram,
  output logic [7:0]        palette_addr,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int CNT_W = $clog2(DATA_W / 2 + 1);

  typedef enum logic [1:0] {BPP8 = 2'd0, BPP4 = 2'd1, BPP2 = 2'd2} bpp_e;

  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_shift_cnt;
  logic [ADDR_W-1:0] r_line_base, r_fetch_addr, r_vram_addr;
  logic [9:0]        r_words_fetched;
  logic              r_fetch_en, r_vram_req, r_underrun;
  logic [7:0]        r_palette_addr;
  bpp_e              r_bpp;

  logic              w_reload, w_active, w_shift_empty, w_fifo_empty;
  logic              w_emit, w_pop, w_starve, w_ack, w_req_ok;
  logic [CW-1:0]     w_count_next;
  logic [9:0]        w_wf_next;
  logic [ADDR_W-1:0] w_fetch_addr_next, w_new_base;
  logic [DATA_W-1:0] w_src_word, w_shifted;
  logic [7:0]        w_pix;
  logic [CNT_W-1:0]  w_ppw_m1;
  bpp_e              w_bpp_sel;

  assign w_reload      = (cx == 10'(RELOAD_X));
  assign w_active      = on_a_visible_line && (cx >= view_start_x) && (cx < view_end_x);
  assign w_shift_empty = (r_shift_cnt == '0);
  assign w_fifo_empty  = (r_count == '0);
  assign w_emit        = w_active && (!w_shift_empty || !w_fifo_empty);
  assign w_pop         = w_active && w_shift_empty && !w_fifo_empty;
  assign w_starve      = w_active && w_shift_empty && w_fifo_empty;

  // An acknowledge is taken only for our own outstanding request and never in the reload cycle.
  assign w_ack             = r_vram_req && vram.vram_ack && !w_reload;
  assign w_count_next      = r_count + CW'(w_ack) - CW'(w_pop);
  assign w_wf_next         = r_words_fetched + 10'(w_ack);
  assign w_fetch_addr_next = r_fetch_addr + ADDR_W'(w_ack);
  assign w_req_ok          = r_fetch_en && (w_count_next < CW'(FIFO_DEPTH)) &&
                             (w_wf_next < words_per_line);
  assign w_new_base        = last_line         ? page_addr :
                             on_a_visible_line ? r_line_base + line_stride : r_line_base;
  assign w_src_word        = w_shift_empty ? r_fifo[r_rd_ptr] : r_shift;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_pix     = w_src_word[7:0];
    w_shifted = w_src_word >> 8;
    w_ppw_m1  = CNT_W'(DATA_W / 8 - 1);
    w_bpp_sel = BPP8;
    case (r_bpp)
      BPP4: begin
        w_pix     = {palette_bank[5:2], w_src_word[3:0]};
        w_shifted = w_src_word >> 4;
        w_ppw_m1  = CNT_W'(DATA_W / 4 - 1);
      end
      BPP2: begin
        w_pix     = {palette_bank, w_src_word[1:0]};
        w_shifted = w_src_word >> 2;
        w_ppw_m1  = CNT_W'(DATA_W / 2 - 1);
      end
      default: ;
    endcase
    case (bpp_mode)
      2'd1:    w_bpp_sel = BPP4;
      2'd2:    w_bpp_sel = BPP2;
      default: w_bpp_sel = BPP8;
    endcase
  end

  // NOTE: the FIFO storage is not reset. Emptiness is tracked only by the count and pointers, so stale words are never read.
  always_ff @(posedge clk) begin
    if (w_ack) r_fifo[r_wr_ptr] <= vram.vram_rdata;
  end

  // NOTE: sequential state uses only non-blocking assignments, so every right-hand side sees the values from before the edge.
  always_ff @(posedge clk) begin
    if (!reset_n || !vdp_super) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_shift         <= '0;
      r_shift_cnt     <= '0;
      r_line_base     <= '0;
      r_fetch_addr    <= '0;
      r_vram_addr     <= '0;
      r_words_fetched <= '0;
      r_fetch_en      <= 1'b0;
      r_vram_req      <= 1'b0;
      r_underrun      <= 1'b0;
      r_palette_addr  <= '0;
      r_bpp           <= BPP8;
    end else begin
      r_palette_addr <= w_emit ? w_pix : frame_col;
      if (w_starve)          r_underrun <= 1'b1;
      else if (underrun_clr) r_underrun <= 1'b0;

      if (w_reload) begin
        r_line_base     <= w_new_base;
        r_fetch_addr    <= w_new_base;
        r_words_fetched <= '0;
        r_wr_ptr        <= '0;
        r_rd_ptr        <= '0;
        r_count         <= '0;
        r_shift_cnt     <= '0;
        r_fetch_en      <= 1'b1;
        r_bpp           <= w_bpp_sel;
        r_vram_req      <= 1'b0;
      end else begin
        if (w_ack) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count         <= w_count_next;
        r_fetch_addr    <= w_fetch_addr_next;
        r_words_fetched <= w_wf_next;

        // A popped word emits its first pixel in the same slot, so the remaining count starts at pixels-per-word minus one.
        if (w_pop) begin
          r_shift     <= w_shifted;
          r_shift_cnt <= w_ppw_m1;
        end else if (w_emit) begin
          r_shift     <= w_shifted;
          r_shift_cnt <= r_shift_cnt - CNT_W'(1);
        end

        if (!(r_vram_req && !vram.vram_ack)) begin
          r_vram_req <= w_req_ok;
          if (w_req_ok) r_vram_addr <= w_fetch_addr_next;
        end
      end
    end
  end

  assign vram.vram_req  = r_vram_req;
  assign vram.vram_addr = r_vram_addr;
  assign palette_addr   = r_palette_addr;
  assign underrun       = r_underrun;

endmodule
